remote_comm: RTL and testbench



---
 rtl/remote_comm.sv | 234 +++++++++++++++++++++++
 tb/tb_remote_comm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// Host-side command sender: ships a 16-bit command as two UART bytes (high first),
// then waits for a one-byte reply. Optional response timeout under RESP_TIMEOUT_EN.
module uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  input  logic       clr_rdy,
  output logic       TX,
  output logic       tx_done,
  output logic       rdy,
  output logic [7:0] rx_data
);
  localparam int BW = $clog2(BAUD_DIV + 1);

  logic [9:0]    tx_sh_q;
  logic [BW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic          tx_busy_q, tx_done_q;

  // Shift register refills with ones, so the line rests high between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_q   <= '1;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else if (trmt) begin
      tx_sh_q   <= {1'b1, tx_data, 1'b0};
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_busy_q <= 1'b1;
      tx_done_q <= 1'b0;
    end else if (tx_busy_q) begin
      if (tx_baud_q == BW'(BAUD_DIV - 1)) begin
        tx_baud_q <= '0;
        tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
        tx_bit_q  <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
        end
      end else begin
        tx_baud_q <= tx_baud_q + BW'(1);
      end
    end
  end

  assign TX      = tx_sh_q[0];
  assign tx_done = tx_done_q;

  logic          rx_meta_q, rx_sync_q, rx_busy_q, rdy_q;
  logic [BW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q, rx_data_q;

  // Bit 0 is the start bit (re-checked mid-bit to reject glitches), 9 is the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      if (clr_rdy) rdy_q <= 1'b0;
      if (!rx_busy_q && !rx_sync_q) begin
        rx_busy_q <= 1'b1;
        rx_cnt_q  <= BW'(BAUD_DIV / 2);
        rx_bit_q  <= '0;
      end else if (rx_busy_q) begin
        if (rx_cnt_q != '0) begin
          rx_cnt_q <= rx_cnt_q - BW'(1);
        end else begin
          rx_cnt_q <= BW'(BAUD_DIV - 1);
          if (rx_bit_q == 4'd0 && rx_sync_q) begin
            rx_busy_q <= 1'b0;
          end else if (rx_bit_q == 4'd9) begin
            rx_busy_q <= 1'b0;
            rx_data_q <= rx_sh_q;
            rdy_q     <= 1'b1;
          end else begin
            if (rx_bit_q != 4'd0) rx_sh_q <= {rx_sync_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 4'd1;
          end
        end
      end
    end
  end

  assign rdy     = rdy_q;
  assign rx_data = rx_data_q;
endmodule

module remote_comm #(
  parameter int BAUD_DIV       = 2604,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy
`ifdef RESP_TIMEOUT_EN
  ,output logic       resp_timeout
`endif
);
  typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW, WAIT_RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q;
  logic        cmd_snt_q, resp_rdy_q;
  logic [7:0]  resp_q;
  logic        trmt, tx_done, rdy, clr_rdy;
  logic [7:0]  tx_data, rx_data;
  logic        accept, snt_set, capture, expire;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .trmt(trmt), .tx_data(tx_data),
    .clr_rdy(clr_rdy), .TX(TX), .tx_done(tx_done), .rdy(rdy), .rx_data(rx_data)
  );

`ifdef RESP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;
  logic          resp_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        to_cnt_q <= '0;
    else if (state_q == TX_LOW && state_d == WAIT_RESP) to_cnt_q <= '0;
    else if (state_q == WAIT_RESP)                      to_cnt_q <= to_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      resp_timeout_q <= 1'b0;
    else if (accept) resp_timeout_q <= 1'b0;
    else if (expire) resp_timeout_q <= 1'b1;
  end

  assign expire       = (state_q == WAIT_RESP) && !rdy && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign resp_timeout = resp_timeout_q;
`else
  assign expire = 1'b0;
`endif

  // Any byte arriving outside WAIT_RESP is flushed so it cannot pose as the reply.
  always_comb begin
    state_d = state_q;
    trmt    = 1'b0;
    tx_data = 8'h00;
    clr_rdy = 1'b0;
    accept  = 1'b0;
    snt_set = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        clr_rdy = rdy;
        if (snd_cmd) begin
          accept  = 1'b1;
          trmt    = 1'b1;
          tx_data = cmd[15:8];
          clr_rdy = 1'b1;
          state_d = TX_HIGH;
        end
      end
      TX_HIGH: begin
        clr_rdy = rdy;
        if (tx_done) begin
          trmt    = 1'b1;
          tx_data = hold_q[7:0];
          state_d = TX_LOW;
        end
      end
      TX_LOW: begin
        clr_rdy = rdy;
        if (tx_done) begin
          snt_set = 1'b1;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (rdy) begin
          capture = 1'b1;
          clr_rdy = 1'b1;
          state_d = IDLE;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      cmd_snt_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_q     <= cmd;
        cmd_snt_q  <= 1'b0;
        resp_rdy_q <= 1'b0;
      end
      if (snt_set) cmd_snt_q <= 1'b1;
      if (capture) begin
        resp_q     <= rx_data;
        resp_rdy_q <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign cmd_snt  = cmd_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;
endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: bit-level TX monitor plus a far-end byte driver on RX.
module tb_remote_comm;
  localparam int B  = 8;
  localparam int TO = 1000;

  logic        clk = 1'b0, rst_n = 1'b0, snd_cmd = 1'b0, RX = 1'b1;
  logic [15:0] cmd = '0;
  logic        TX, busy, cmd_snt, resp_rdy;
  logic [7:0]  resp;
`ifdef RESP_TIMEOUT_EN
  logic        resp_timeout;
`endif
  int          errs = 0, checks = 0;
  logic [7:0]  mon_q[$];

  remote_comm #(.BAUD_DIV(B), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .RX(RX), .TX(TX),
    .busy(busy), .cmd_snt(cmd_snt), .resp(resp), .resp_rdy(resp_rdy)
`ifdef RESP_TIMEOUT_EN
    ,.resp_timeout(resp_timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        repeat (B/2) @(negedge clk);
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        mon_q.push_back(b);
      end
    end
  end

  task automatic pulse_cmd(input logic [15:0] c);
    @(negedge clk); snd_cmd = 1'b1; cmd = c;
    @(negedge clk); snd_cmd = 1'b0; cmd = ~c;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); RX = fr[i];
      repeat (B-1) @(negedge clk);
    end
  endtask

  task automatic wait_snt(output int n);
    n = 0;
    while (cmd_snt !== 1'b1 && n < 30*B) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 30*B) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1)     begin errs++; $display("FAIL rst_tx got %b want 1", TX); end
    checks++; if (busy !== 1'b0)   begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (cmd_snt !== 1'b0) begin errs++; $display("FAIL rst_cmd_snt got %b want 0", cmd_snt); end
    checks++; if (resp !== 8'h00)  begin errs++; $display("FAIL rst_resp got %h want 00", resp); end
    checks++; if (resp_rdy !== 1'b0) begin errs++; $display("FAIL rst_resp_rdy got %b want 0", resp_rdy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    mon_q.delete();
    pulse_cmd(16'hA5C3);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_rise got %b want 1", busy); end
    wait_snt(n);
    // high byte 10 bit-times, low byte issued one cycle after tx_done, plus register stage
    checks++; if (cmd_snt !== 1'b1 || n < 20*B - 2 || n > 20*B + 4)
      begin errs++; $display("FAIL basic_cmd_snt got %b after %0d want 1 after ~%0d", cmd_snt, n, 20*B); end
    repeat (2*B) @(negedge clk);
    checks++; if (mon_q.size() !== 2 || mon_q[0] !== 8'hA5 || mon_q[1] !== 8'hC3)
      begin errs++; $display("FAIL basic_bytes got %0d bytes want A5 C3", mon_q.size()); end
    checks++; if (busy !== 1'b1 || resp_rdy !== 1'b0)
      begin errs++; $display("FAIL basic_wait got busy=%b rdy=%b want 1 0", busy, resp_rdy); end
    send_byte(8'h5A);
    wait_idle(n);
    checks++; if (resp !== 8'h5A || resp_rdy !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL basic_resp got %h/%b/%b want 5a/1/0", resp, resp_rdy, busy); end
  endtask

  task automatic test_byte_order;
    int n;
    mon_q.delete();
    pulse_cmd(16'h1200);
    checks++; if (resp_rdy !== 1'b0 || cmd_snt !== 1'b0 || resp !== 8'h5A)
      begin errs++; $display("FAIL order_clear got rdy=%b snt=%b resp=%h want 0 0 5a", resp_rdy, cmd_snt, resp); end
    wait_snt(n);
    repeat (2*B) @(negedge clk);
    checks++; if (mon_q.size() !== 2 || mon_q[0] !== 8'h12 || mon_q[1] !== 8'h00)
      begin errs++; $display("FAIL order_bytes got %0d bytes want 12 00", mon_q.size()); end
    send_byte(8'h3C);
    wait_idle(n);
    checks++; if (resp !== 8'h3C || resp_rdy !== 1'b1)
      begin errs++; $display("FAIL order_resp got %h/%b want 3c/1", resp, resp_rdy); end
  endtask

  task automatic test_busy_reject;
    int n;
    mon_q.delete();
    pulse_cmd(16'hBEEF);
    repeat (5) @(negedge clk);
    pulse_cmd(16'h0F0F);
    repeat (12*B) @(negedge clk);
    pulse_cmd(16'h0F0F);
    wait_snt(n);
    pulse_cmd(16'h0F0F);
    send_byte(8'h11);
    wait_idle(n);
    repeat (12*B) @(negedge clk);
    checks++; if (mon_q.size() !== 2 || mon_q[0] !== 8'hBE || mon_q[1] !== 8'hEF)
      begin errs++; $display("FAIL reject_bytes got %0d bytes want BE EF", mon_q.size()); end
    checks++; if (resp !== 8'h11 || busy !== 1'b0)
      begin errs++; $display("FAIL reject_resp got %h busy=%b want 11 0", resp, busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    pulse_cmd(16'h3333);
    repeat (3*B) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (TX !== 1'b1 || busy !== 1'b0 || cmd_snt !== 1'b0 || resp_rdy !== 1'b0)
      begin errs++; $display("FAIL midrst got tx=%b busy=%b snt=%b rdy=%b want 1 0 0 0", TX, busy, cmd_snt, resp_rdy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12*B) @(negedge clk);
    mon_q.delete();
    pulse_cmd(16'h4444);
    wait_snt(n);
    repeat (2*B) @(negedge clk);
    checks++; if (mon_q.size() !== 2 || mon_q[0] !== 8'h44 || mon_q[1] !== 8'h44)
      begin errs++; $display("FAIL midrst_bytes got %0d bytes want 44 44", mon_q.size()); end
    send_byte(8'h66);
    wait_idle(n);
    checks++; if (resp !== 8'h66 || resp_rdy !== 1'b1)
      begin errs++; $display("FAIL midrst_resp got %h/%b want 66/1", resp, resp_rdy); end
  endtask

  task automatic test_stray;
    int n;
    send_byte(8'h77);
    repeat (4*B) @(negedge clk);
    checks++; if (resp !== 8'h66 || busy !== 1'b0)
      begin errs++; $display("FAIL stray_idle got %h busy=%b want 66 0", resp, busy); end
    pulse_cmd(16'h0102);
    wait_snt(n);
    checks++; if (busy !== 1'b1)
      begin errs++; $display("FAIL stray_wait got busy=%b want 1", busy); end
    send_byte(8'h99);
    wait_idle(n);
    checks++; if (resp !== 8'h99 || resp_rdy !== 1'b1)
      begin errs++; $display("FAIL stray_resp got %h/%b want 99/1", resp, resp_rdy); end
  endtask

`ifdef RESP_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    pulse_cmd(16'hCAFE);
    checks++; if (resp_timeout !== 1'b0)
      begin errs++; $display("FAIL to_clear got %b want 0", resp_timeout); end
    wait_snt(n);
    n = 0;
    while (resp_timeout !== 1'b1 && n < 2*TO) begin @(negedge clk); n++; end
    checks++; if (resp_timeout !== 1'b1 || n != TO)
      begin errs++; $display("FAIL to_time got %b after %0d want 1 after %0d", resp_timeout, n, TO); end
    checks++; if (resp_rdy !== 1'b0 || busy !== 1'b0 || resp !== 8'h99)
      begin errs++; $display("FAIL to_state got rdy=%b busy=%b resp=%h want 0 0 99", resp_rdy, busy, resp); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_byte_order();
    test_busy_reject();
    test_reset_mid();
    test_stray();
`ifdef RESP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
